// File: rtl/frame_aligner_gen.sv
// Frame aligner: hunts for header A or B, locks after LOCK_CNT good frames, unlocks after
// UNLOCK_CNT consecutive bad headers. Optional macro FA_ERR_CNT_EN adds err_cnt/err_clr.
module frame_aligner_gen #(
  parameter int DATA_W      = 8,
  parameter int HDR_LEN     = 2,
  parameter logic [HDR_LEN*DATA_W-1:0] HDR_A = 16'hAFAA,
  parameter logic [HDR_LEN*DATA_W-1:0] HDR_B = 16'hBA55,
  parameter int PAYLOAD_LEN = 10,
  parameter int LOCK_CNT    = 3,
  parameter int UNLOCK_CNT  = 4,
  localparam int OPOS_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
`ifdef FA_ERR_CNT_EN
  input  logic              err_clr,
  output logic [15:0]       err_cnt,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [OPOS_W-1:0] fr_byte_position,
  output logic              frame_start,
  output logic              hdr_type,
  output logic              frame_detect,
  output logic [1:0]        state_o
);

  // Handshake: no backpressure. Each cycle with rx_valid=1 delivers one word that is always
  // consumed; out_valid qualifies out_data for exactly one cycle and cannot be stalled.

  localparam int FRAME_LEN = PAYLOAD_LEN + HDR_LEN;
  localparam int POS_W     = $clog2(FRAME_LEN);
  localparam int GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam int BAD_W     = $clog2(UNLOCK_CNT + 1);
  localparam int WIN_W     = HDR_LEN * DATA_W;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [GOOD_W-1:0]   good_q, good_d, good_inc;
  logic [BAD_W-1:0]    bad_q, bad_d, bad_inc;
  logic                hdr_type_q, hdr_type_d;
  logic [WIN_W-1:0]    window;
  logic                match_a, match_b, match, at_hdr;

  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [OPOS_W-1:0]   out_pos_q, out_pos_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_start_q, frame_start_d;

  // Header window: current word on top, older valid words below (first word in the LSBs).
  generate
    if (HDR_LEN == 1) begin : g_win1
      assign window = rx_data;
    end else begin : g_winn
      logic [WIN_W-DATA_W-1:0] prev_q;
      assign window = {rx_data, prev_q};
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      prev_q <= '0;
        else if (rx_valid) prev_q <= window[WIN_W-1:DATA_W];
      end
    end
  endgenerate

  assign match_a  = (window == HDR_A);
  assign match_b  = (window == HDR_B);
  assign match    = match_a | match_b;
  assign at_hdr   = (pos_q == POS_W'(FRAME_LEN - 1));
  assign good_inc = (good_q == {GOOD_W{1'b1}}) ? good_q : good_q + 1'b1;
  assign bad_inc  = (bad_q == {BAD_W{1'b1}}) ? bad_q : bad_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HUNT;
      pos_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      hdr_type_q    <= 1'b0;
      out_data_q    <= '0;
      out_pos_q     <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      hdr_type_q    <= hdr_type_d;
      out_data_q    <= out_data_d;
      out_pos_q     <= out_pos_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    good_d     = good_q;
    bad_d      = bad_q;
    hdr_type_d = hdr_type_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (match) begin
            state_d    = (LOCK_CNT == 1) ? ST_LOCKED : ST_SYNC;
            pos_d      = '0;
            good_d     = GOOD_W'(1);
            bad_d      = '0;
            hdr_type_d = ~match_a;
          end
        end
        ST_SYNC: begin
          pos_d = at_hdr ? '0 : pos_q + 1'b1;
          if (at_hdr) begin
            if (match) begin
              good_d     = good_inc;
              hdr_type_d = ~match_a;
              if (good_inc >= GOOD_W'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                bad_d   = '0;
              end
            end else begin
              // The failing window cannot match as a HUNT header either, so just fall back.
              state_d = ST_HUNT;
              good_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          pos_d = at_hdr ? '0 : pos_q + 1'b1;
          if (at_hdr) begin
            if (match) begin
              bad_d      = '0;
              hdr_type_d = ~match_a;
            end else if (bad_inc >= BAD_W'(UNLOCK_CNT)) begin
              state_d = ST_HUNT;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    out_data_d    = out_data_q;
    out_pos_d     = out_pos_q;
    if (rx_valid) begin
      out_data_d    = rx_data;
      out_pos_d     = pos_q[OPOS_W-1:0];
      out_valid_d   = (state_q == ST_LOCKED) && (pos_q < POS_W'(PAYLOAD_LEN));
      frame_start_d = out_valid_d && (pos_q == '0);
    end
  end

  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign fr_byte_position = out_pos_q;
  assign frame_start      = frame_start_q;
  assign hdr_type         = hdr_type_q;
  assign frame_detect     = (state_q == ST_LOCKED);
  assign state_o          = state_q;

`ifdef FA_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        err_inc;
  assign err_inc = rx_valid && (state_q == ST_LOCKED) && at_hdr && !match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           err_cnt_q <= '0;
    else if (err_clr)                       err_cnt_q <= '0;
    else if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
  end
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_frame_aligner_gen.sv
// Directed bench for frame_aligner_gen: stimulus pushes expected payload outputs into a
// queue, a negedge monitor pops and compares whenever out_valid is seen.
module tb_frame_aligner_gen;
  localparam int DW = 8;
  localparam int PW = 4;
  localparam int EW = 1 + 1 + PW + DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [PW-1:0] fr_byte_position;
  logic          frame_start;
  logic          hdr_type;
  logic          frame_detect;
  logic [1:0]    state_o;
`ifdef FA_ERR_CNT_EN
  logic          err_clr = 1'b0;
  logic [15:0]   err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  frame_aligner_gen dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
`ifdef FA_ERR_CNT_EN
    .err_clr          (err_clr),
    .err_cnt          (err_cnt),
`endif
    .out_data         (out_data),
    .out_valid        (out_valid),
    .fr_byte_position (fr_byte_position),
    .frame_start      (frame_start),
    .hdr_type         (hdr_type),
    .frame_detect     (frame_detect),
    .state_o          (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: each call occupies exactly one clock cycle.
  task automatic put(input logic [DW-1:0] d, input bit e, input int p, input bit h);
    rx_data  = d;
    rx_valid = 1'b1;
    if (e) exp_q.push_back({h, (p == 0), PW'(p), d});
    @(posedge clk); #1;
  endtask

  task automatic gap();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic hdr(input logic [DW-1:0] h0, input logic [DW-1:0] h1);
    put(h0, 1'b0, 0, 1'b0);
    put(h1, 1'b0, 0, 1'b0);
  endtask

  task automatic payload(input logic [DW-1:0] base, input bit e, input bit h);
    for (int i = 0; i < 10; i++) put(base + DW'(i), e, i, h);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got data %0h pos %0d, expected no output", out_data, fr_byte_position);
      end else begin
        mon_e = exp_q.pop_front();
        chk("payload{hdr,fs,pos,data}", {18'd0, hdr_type, frame_start, fr_byte_position, out_data},
            {18'd0, mon_e});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pos", fr_byte_position, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_hdr_type", hdr_type, 0);
    chk("rst_frame_detect", frame_detect, 0);
    chk("rst_state", state_o, 0);
    reset_n = 1'b1;

    // 1: three clean A frames lock; payload after the locking header is emitted.
    hdr(8'hAA, 8'hAF);
    chk("t1_sync_after_h1", state_o, 1);
    payload(8'h00, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t1_sync_after_h2", state_o, 1);
    chk("t1_fd_after_h2", frame_detect, 0);
    payload(8'h00, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t1_fd_after_h3", frame_detect, 1);
    chk("t1_locked", state_o, 2);
    payload(8'h00, 1'b1, 1'b0);

    // 2: gap after every word, including inside the header.
    put(8'hAA, 1'b0, 0, 1'b0); gap();
    put(8'hAF, 1'b0, 0, 1'b0); gap();
    for (int i = 0; i < 10; i++) begin
      put(8'h10 + DW'(i), 1'b1, i, 1'b0);
      gap();
      if (i == 0) begin
        chk("t2_gap_no_valid", out_valid, 0);
        chk("t2_gap_data_hold", out_data, 8'h10);
      end
    end
    chk("t2_still_locked", frame_detect, 1);

    // 3: four bad headers drop lock; the first three keep frame timing.
    for (int k = 0; k < 3; k++) begin
      hdr(8'h12, 8'h34);
      chk("t3_hold_lock", frame_detect, 1);
      payload(8'h20, 1'b1, 1'b0);
    end
    hdr(8'h12, 8'h34);
    chk("t3_unlock_state", state_o, 0);
    chk("t3_unlock_fd", frame_detect, 0);
`ifdef FA_ERR_CNT_EN
    chk("t3_err_cnt", err_cnt, 4);
    err_clr = 1'b1;
    gap();
    err_clr = 1'b0;
    chk("t3_err_clr", err_cnt, 0);
`endif
    payload(8'h30, 1'b0, 1'b0);

    // 4: relock, three bad then a good B header keeps lock and resets the bad count.
    hdr(8'hAA, 8'hAF); payload(8'h40, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF); payload(8'h40, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t4_relock", frame_detect, 1);
    payload(8'h40, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      hdr(8'h12, 8'h34);
      payload(8'h50, 1'b1, 1'b0);
    end
    hdr(8'h55, 8'hBA);
    chk("t4_fd_after_b", frame_detect, 1);
    chk("t4_hdr_type_b", hdr_type, 1);
    payload(8'h60, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      hdr(8'h12, 8'h34);
      payload(8'h70, 1'b1, 1'b1);
    end
    chk("t4_bad_cnt_was_reset", frame_detect, 1);
`ifdef FA_ERR_CNT_EN
    chk("t4_err_cnt", err_cnt, 6);
`endif
    hdr(8'h55, 8'hBA);
    payload(8'h80, 1'b1, 1'b1);

    // 5: noise in HUNT, then one good and one bad header in SYNC.
    do_reset();
    chk("t5_rst_hdr_type", hdr_type, 0);
    put(8'h00, 1'b0, 0, 1'b0);
    put(8'hAA, 1'b0, 0, 1'b0);
    put(8'h00, 1'b0, 0, 1'b0);
    put(8'hAF, 1'b0, 0, 1'b0);
    chk("t5_noise_hunt", state_o, 0);
    hdr(8'hAA, 8'hAF);
    chk("t5_sync", state_o, 1);
    payload(8'h90, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t5_sync_good2", state_o, 1);
    payload(8'h90, 1'b0, 1'b0);
    hdr(8'h12, 8'h34);
    chk("t5_back_to_hunt", state_o, 0);

    // 6: reset mid-payload while locked, then relock from scratch.
    hdr(8'hAA, 8'hAF); payload(8'hA0, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF); payload(8'hA0, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t6_locked", frame_detect, 1);
    for (int i = 0; i < 5; i++) put(8'hA0 + DW'(i), 1'b1, i, 1'b0);
    @(negedge clk); #1;
    reset_n  = 1'b0;
    rx_data  = 8'hA5;
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_out_data", out_data, 0);
    chk("t6_async_fd", frame_detect, 0);
    chk("t6_async_state", state_o, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
`ifdef FA_ERR_CNT_EN
    chk("t6_err_cnt_rst", err_cnt, 0);
`endif
    for (int i = 6; i < 10; i++) put(8'hA0 + DW'(i), 1'b0, i, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t6_resync1", state_o, 1);
    payload(8'hB0, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t6_resync2_fd", frame_detect, 0);
    payload(8'hB0, 1'b0, 1'b0);
    hdr(8'hAA, 8'hAF);
    chk("t6_relocked", frame_detect, 1);
    payload(8'hB0, 1'b1, 1'b0);

    repeat (3) gap();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
